sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Two-master front end that sits directly upstream of the 16Mx16 SDRAM controller.
- Arbitrates between port 0 (instruction fetch) and port 1 (data load/store).
- Registers the winning request and holds address, data and mask stable on the controller's valid/ready interface until the controller's one-cycle ready pulse.
- Routes the read data and ready back to the granted master only.

Parameters:
- ADDR_W, 25, byte address width on ports and memory side.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority (port 0 always wins).
- TIMEOUT_CYCLES, 0, watchdog limit in cycles for an outstanding memory request; 0 = disabled.

Ports:
- clk  in  1  system clock, also the SDRAM controller clock.
- reset  in  1  synchronous, active-high reset.
- p0_valid  in  1  port 0 request; held until p0_ready.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_wmask  in  4  port 0 byte enables; 0 = read.
- p0_rdata  out  32  port 0 read data; valid while p0_ready=1.
- p0_ready  out  1  port 0 completion pulse, one cycle.
- p1_valid, p1_addr, p1_wdata, p1_wmask, p1_rdata, p1_ready: same as port 0, for port 1.
- mem_valid  out  1  request to the controller.
- mem_addr  out  ADDR_W  registered address to the controller.
- mem_wdata  out  32  registered write data.
- mem_wmask  out  4  registered byte mask.
- mem_rdata  in  32  controller read data; valid with mem_ready.
- mem_ready  in  1  controller completion pulse, one cycle.
- busy  out  1  a request is outstanding (state != IDLE).
- timeout_err  out  1  sticky flag: watchdog expired at least once.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state=IDLE; mem_valid=0; mem_addr, mem_wdata, mem_wmask=0.
  - p0_ready, p1_ready=0; p0_rdata, p1_rdata=0.
  - busy=0; timeout_err=0; last_grant=1, so port 0 wins the first tie.
  - Watchdog counter=0.
- All outputs are registered.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any pN_valid, select a winner.
  - PRIO_MODE=0: the port not equal to last_grant wins a tie; a single requester wins outright.
  - PRIO_MODE=1: port 0 wins any tie.
  - Latch the winner's addr, wdata and wmask into mem_* and record grant in grant_id.
  - Set mem_valid=1 and go to ISSUE; mem_valid is seen 1 cycle after the grant cycle.
  - No grant is made if neither port is valid.
- ISSUE:
  - Hold mem_valid and all mem_* constant. The controller samples addr and wmask live in several states, so any change here is a protocol violation.
  - On mem_ready=1: capture mem_rdata into p[grant_id]_rdata, pulse p[grant_id]_ready next cycle, clear mem_valid, set last_grant=grant_id, go to RESP.
- RESP:
  - Exactly one cycle: pN_ready=1 for the granted port only.
  - No new grant is allowed in this cycle, because the acknowledged master may still drive valid.
  - Next cycle go to IDLE, pN_ready=0.
  - Minimum spacing from mem_ready to the next mem_valid rising edge is 3 cycles.
- Read data of the non-granted port is unchanged.
- Write requests return the captured mem_rdata as don't-care; benches must not check it.
- Requests not granted stay pending; the arbiter never drops or reorders a held request.
- Round-robin guarantees a continuously requesting port waits at most one foreign transaction.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter resets on entering ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES, set timeout_err=1 (sticky until reset).
  - The request is NOT aborted; the arbiter keeps waiting for mem_ready.
  - The counter saturates.
- Simultaneous mem_ready in a non-ISSUE state is ignored.
- Reset in any state aborts immediately: mem_valid=0 next cycle, and no pN_ready is issued for the aborted request.
- Changes to pN_* inputs while their request is latched have no effect until the next grant.

Decomposition:
- Shared package sdram_pkg:
  - state encoding (IDLE/ISSUE/RESP)
  - ADDR_W default
  - port-id constants PORT0/PORT1
  - byte-mask width constant.
- One natural sub-module: rr_arbiter2. It is a combinational grant from two requests, last_grant and PRIO_MODE.
- The FSM, request register and watchdog stay in the top.

Test Plan:
- Port 0 only: p0 read at addr 0x0000100, controller model asserts mem_ready after 8 cycles with 0xDEADBEEF -> mem_addr=0x0000100, mem_wmask=0; p0_rdata=0xDEADBEEF with a one-cycle p0_ready; p1_ready stays 0.
- Simultaneous requests, PRIO_MODE=0, both held for 4 transactions -> grant order p0, p1, p0, p1; mem_valid gap of at least 3 cycles after each mem_ready.
- PRIO_MODE=1, both held -> p0 granted repeatedly; p1 granted only after p0_valid drops.
- p1 write 0xCAFEF00D, wmask=4'b0011, with p1 inputs changed during ISSUE -> mem_wdata and mem_wmask remain 0xCAFEF00D and 0011 until mem_ready.
- TIMEOUT_CYCLES=16, mem_ready withheld for 20 cycles -> timeout_err rises in the 16th ISSUE cycle; p1_ready still pulses after mem_ready; flag stays 1.
- reset=1 during ISSUE -> next cycle mem_valid=0, busy=0, timeout_err=0, no pN_ready pulse; a fresh p0 request after release is served normally.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared constants for the two-port SDRAM front end: state encoding, port ids
// and data/mask widths.
package sdram_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sdram_port_arbiter_arb.sv
// Combinational two-request grant: round-robin on last_grant, or port 0 fixed
// priority when PRIO_MODE=1.
module rr_arbiter2
    import sdram_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_id_o    = PORT0;
        if (req0_i && req1_i) begin
            gnt_id_o = (PRIO_MODE == 1) ? PORT0 : ~last_grant_i;
        end else if (req1_i) begin
            gnt_id_o = PORT1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of the SDRAM controller: registers the winning
// request, holds it until mem_ready, and routes rdata/ready to the granted port.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int PRIO_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_wmask,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_wmask,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ready,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic              p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              arb_valid, arb_id;

    rr_arbiter2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .req0_i      (p0_valid),
        .req1_i      (p1_valid),
        .last_grant_i(last_grant_q),
        .gnt_valid_o (arb_valid),
        .gnt_id_o    (arb_id)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_ready_d   = 1'b0;
        p1_ready_d   = 1'b0;
        timeout_d    = timeout_q;
        wdog_d       = wdog_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_id;
                    mem_addr_d  = (arb_id == PORT1) ? p1_addr  : p0_addr;
                    mem_wdata_d = (arb_id == PORT1) ? p1_wdata : p0_wdata;
                    mem_wmask_d = (arb_id == PORT1) ? p1_wmask : p0_wmask;
                    mem_valid_d = 1'b1;
                    wdog_d      = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Watchdog only flags; the request keeps waiting for mem_ready.
                if (TIMEOUT_CYCLES > 0) begin
                    if (wdog_q != CNT_MAX) wdog_d = wdog_q + 1'b1;
                    if (wdog_d == CNT_MAX) timeout_d = 1'b1;
                end
                if (mem_ready) begin
                    if (grant_q == PORT1) begin
                        p1_rdata_d = mem_rdata;
                        p1_ready_d = 1'b1;
                    end else begin
                        p0_rdata_d = mem_rdata;
                        p0_ready_d = 1'b1;
                    end
                    mem_valid_d  = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = ST_RESP;
                end
            end
            // The acknowledged master may still hold valid here, so no grant.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= PORT0;
            last_grant_q <= PORT1;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_ready_q   <= 1'b0;
            p1_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_ready_q   <= p0_ready_d;
            p1_ready_q   <= p1_ready_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            wdog_q       <= wdog_d;
        end
    end

    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign p0_ready    = p0_ready_q;
    assign p1_ready    = p1_ready_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: instance 0 is round-robin with a 16-cycle watchdog, instance 1
// is fixed priority; inputs driven and outputs sampled on the falling edge.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        reset       [2];
    logic        p0_valid    [2];
    logic        p1_valid    [2];
    logic [24:0] p0_addr     [2];
    logic [24:0] p1_addr     [2];
    logic [31:0] p0_wdata    [2];
    logic [31:0] p1_wdata    [2];
    logic [3:0]  p0_wmask    [2];
    logic [3:0]  p1_wmask    [2];
    logic [31:0] p0_rdata    [2];
    logic [31:0] p1_rdata    [2];
    logic        p0_ready    [2];
    logic        p1_ready    [2];
    logic        mem_valid   [2];
    logic [24:0] mem_addr    [2];
    logic [31:0] mem_wdata   [2];
    logic [3:0]  mem_wmask   [2];
    logic [31:0] mem_rdata   [2];
    logic        mem_ready   [2];
    logic        busy        [2];
    logic        timeout_err [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rd   [2][2];
    bit          rd_known [2][2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_port_arbiter #(
            .ADDR_W        (25),
            .PRIO_MODE     (g),
            .TIMEOUT_CYCLES((g == 0) ? 16 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .p0_valid   (p0_valid[g]),
            .p0_addr    (p0_addr[g]),
            .p0_wdata   (p0_wdata[g]),
            .p0_wmask   (p0_wmask[g]),
            .p0_rdata   (p0_rdata[g]),
            .p0_ready   (p0_ready[g]),
            .p1_valid   (p1_valid[g]),
            .p1_addr    (p1_addr[g]),
            .p1_wdata   (p1_wdata[g]),
            .p1_wmask   (p1_wmask[g]),
            .p1_rdata   (p1_rdata[g]),
            .p1_ready   (p1_ready[g]),
            .mem_valid  (mem_valid[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_wmask  (mem_wmask[g]),
            .mem_rdata  (mem_rdata[g]),
            .mem_ready  (mem_ready[g]),
            .busy       (busy[g]),
            .timeout_err(timeout_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=stuck required=finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int d, input int p);
        return (p == 0) ? p0_ready[d] : p1_ready[d];
    endfunction

    function automatic logic [31:0] get_rdata(input int d, input int p);
        return (p == 0) ? p0_rdata[d] : p1_rdata[d];
    endfunction

    task automatic clear_rd(input int d);
        for (int p = 0; p < 2; p++) begin
            exp_rd[d][p]   = 32'h0;
            rd_known[d][p] = 1'b1;
        end
    endtask

    // One transaction on instance d expected to be granted to `port`;
    // mem_ready is raised in the lat-th ISSUE cycle. Returns in the IDLE cycle.
    task automatic txn(input int d, input int port, input int lat, input logic [31:0] rd,
                       input bit is_write, input bit to_chk, input bit scramble);
        logic [24:0] ea;
        logic [31:0] ew;
        logic [3:0]  em;
        bit          seen;
        int          other;
        other = 1 - port;
        ea = (port == 0) ? p0_addr[d]  : p1_addr[d];
        ew = (port == 0) ? p0_wdata[d] : p1_wdata[d];
        em = (port == 0) ? p0_wmask[d] : p1_wmask[d];
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_valid[d]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("grant_seen", seen, 1);
        check("busy_issue", busy[d], 1);
        for (int k = 1; k <= lat; k++) begin
            check("issue_valid", mem_valid[d], 1);
            check("issue_addr", mem_addr[d], ea);
            check("issue_wdata", mem_wdata[d], ew);
            check("issue_wmask", mem_wmask[d], em);
            if (to_chk) check("timeout_err", timeout_err[d], (k > 16));
            if (scramble && k == 2) begin
                if (port == 0) begin
                    p0_addr[d] = 25'h3FC; p0_wdata[d] = 32'h12345678; p0_wmask[d] = 4'b1111;
                end else begin
                    p1_addr[d] = 25'h3FC; p1_wdata[d] = 32'h12345678; p1_wmask[d] = 4'b1111;
                end
            end
            if (k == lat) begin
                mem_ready[d] = 1'b1;
                mem_rdata[d] = rd;
            end
            tick();
        end
        mem_ready[d] = 1'b0;
        mem_rdata[d] = 32'h0;
        check("resp_ready_gnt", get_ready(d, port), 1);
        check("resp_ready_other", get_ready(d, other), 0);
        check("resp_mem_valid", mem_valid[d], 0);
        if (!is_write) begin
            check("resp_rdata", get_rdata(d, port), rd);
            exp_rd[d][port] = rd;
        end else begin
            rd_known[d][port] = 1'b0;
        end
        if (rd_known[d][other]) check("other_rdata", get_rdata(d, other), exp_rd[d][other]);
        tick();
        check("idle_ready_gnt", get_ready(d, port), 0);
        check("idle_mem_valid_gap", mem_valid[d], 0);
        check("idle_busy", busy[d], 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d]     = 1'b1;
            p0_valid[d]  = 1'b0; p1_valid[d] = 1'b0;
            p0_addr[d]   = '0;   p1_addr[d]  = '0;
            p0_wdata[d]  = '0;   p1_wdata[d] = '0;
            p0_wmask[d]  = '0;   p1_wmask[d] = '0;
            mem_rdata[d] = '0;   mem_ready[d] = 1'b0;
            clear_rd(d);
        end
        tick(); tick(); tick();

        check("rst_mem_valid", mem_valid[0], 0);
        check("rst_mem_addr", mem_addr[0], 0);
        check("rst_mem_wmask", mem_wmask[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_timeout", timeout_err[0], 0);
        check("rst_p0_ready", p0_ready[0], 0);
        check("rst_p1_rdata", p1_rdata[0], 0);
        reset[0] = 1'b0;

        // Round-robin, both held: p0, p1, p0, p1.
        p0_valid[0] = 1'b1; p0_addr[0] = 25'h100;
        p1_valid[0] = 1'b1; p1_addr[0] = 25'h200;
        txn(0, 0, 2, 32'h1111_0001, 0, 0, 0);
        txn(0, 1, 3, 32'h2222_0002, 0, 0, 0);
        txn(0, 0, 2, 32'h1111_0003, 0, 0, 0);
        txn(0, 1, 1, 32'h2222_0004, 0, 0, 0);
        p0_valid[0] = 1'b0; p1_valid[0] = 1'b0;

        // Port 0 alone, 8-cycle read latency.
        p0_valid[0] = 1'b1; p0_addr[0] = 25'h0000100; p0_wmask[0] = 4'b0000;
        txn(0, 0, 8, 32'hDEADBEEF, 0, 0, 0);
        p0_valid[0] = 1'b0;

        // Stray mem_ready while idle.
        mem_ready[0] = 1'b1; mem_rdata[0] = 32'hFFFF_FFFF;
        tick();
        mem_ready[0] = 1'b0; mem_rdata[0] = 32'h0;
        check("stray_p0_ready", p0_ready[0], 0);
        check("stray_p1_ready", p1_ready[0], 0);
        check("stray_busy", busy[0], 0);
        check("stray_p0_rdata", p0_rdata[0], 32'hDEADBEEF);

        // Port 1 write with inputs scrambled during ISSUE.
        p1_valid[0] = 1'b1; p1_addr[0] = 25'h200;
        p1_wdata[0] = 32'hCAFEF00D; p1_wmask[0] = 4'b0011;
        txn(0, 1, 5, 32'h0, 1, 0, 1);
        p1_valid[0] = 1'b0;

        // Watchdog: mem_ready withheld for 20 ISSUE cycles.
        p1_valid[0] = 1'b1; p1_addr[0] = 25'h240; p1_wdata[0] = '0; p1_wmask[0] = '0;
        txn(0, 1, 21, 32'h5555AAAA, 0, 1, 0);
        p1_valid[0] = 1'b0;
        check("timeout_sticky", timeout_err[0], 1);
        tick();
        check("timeout_sticky2", timeout_err[0], 1);

        // Reset during ISSUE, with a coincident mem_ready.
        p0_valid[0] = 1'b1; p0_addr[0] = 25'h300;
        tick();
        check("abort_issue_valid", mem_valid[0], 1);
        tick(); tick();
        reset[0] = 1'b1; p0_valid[0] = 1'b0; mem_ready[0] = 1'b1;
        tick();
        mem_ready[0] = 1'b0;
        check("abort_mem_valid", mem_valid[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_timeout", timeout_err[0], 0);
        check("abort_p0_ready", p0_ready[0], 0);
        check("abort_p1_ready", p1_ready[0], 0);
        reset[0] = 1'b0;
        clear_rd(0);
        tick();
        check("post_abort_p0_ready", p0_ready[0], 0);
        check("post_abort_valid", mem_valid[0], 0);
        p0_valid[0] = 1'b1; p0_addr[0] = 25'h400;
        txn(0, 0, 4, 32'h0BADCAFE, 0, 0, 0);
        p0_valid[0] = 1'b0;

        // Fixed priority instance: p0 wins while held, p1 only after p0 drops.
        reset[1] = 1'b0;
        tick();
        p0_valid[1] = 1'b1; p0_addr[1] = 25'h100;
        p1_valid[1] = 1'b1; p1_addr[1] = 25'h200;
        txn(1, 0, 2, 32'hA0A0_0001, 0, 0, 0);
        txn(1, 0, 3, 32'hA0A0_0002, 0, 0, 0);
        txn(1, 0, 2, 32'hA0A0_0003, 0, 0, 0);
        p0_valid[1] = 1'b0;
        txn(1, 1, 2, 32'hB1B1_0004, 0, 0, 0);
        p1_valid[1] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
